// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch PC sequencer.
package fetch_pkg;

  localparam int DEF_PC_BITS    = 16;
  localparam int DEF_INSTR_BITS = 32;
  localparam int DEF_PC_INC     = 4;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    IDLE   = 2'd1,
    BUSY   = 2'd2,
    SQUASH = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_seq_if.sv
// Instruction-memory request/ack bus between the fetch sequencer (master) and imem (slave).
interface fetch_pc_seq_if
  import fetch_pkg::*;
#(
  parameter int PC_BITS    = DEF_PC_BITS,
  parameter int INSTR_BITS = DEF_INSTR_BITS
) ();

  logic                  imem_req;
  logic [PC_BITS-1:0]    imem_addr;
  logic                  imem_ack;
  logic [INSTR_BITS-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_perf_ctr.sv
// Fetch statistics: captured instructions and redirect cycles (built only with FETCH_PERF_EN).
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture,
  input  logic        redirect,
  output logic [31:0] fetch_count,
  output logic [31:0] redirect_count
);

  logic [31:0] fetch_count_reg;
  logic [31:0] redirect_count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count_reg    <= '0;
      redirect_count_reg <= '0;
    end else begin
      if (capture)  fetch_count_reg    <= fetch_count_reg + 32'd1;
      if (redirect) redirect_count_reg <= redirect_count_reg + 32'd1;
    end
  end

  assign fetch_count    = fetch_count_reg;
  assign redirect_count = redirect_count_reg;

endmodule

// File: rtl/fetch_pc_seq.sv
// Fetch-stage PC sequencer: one outstanding imem request, redirect squash, decode stall.
// Optional FETCH_PERF_EN adds fetch_count / redirect_count outputs.
module fetch_pc_seq
  import fetch_pkg::*;
#(
  parameter int                 PC_BITS    = DEF_PC_BITS,
  parameter int                 INSTR_BITS = DEF_INSTR_BITS,
  parameter logic [PC_BITS-1:0] RESET_PC   = '0,
  parameter int                 PC_INC     = DEF_PC_INC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [PC_BITS-1:0]    redirect_pc,
  fetch_pc_seq_if.master        imem,
  output logic                  instr_valid,
  output logic [INSTR_BITS-1:0] instr_out,
  output logic [PC_BITS-1:0]    instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [31:0]           redirect_count
`endif
);

  fetch_state_t          state_reg, state_next;
  logic [PC_BITS-1:0]    pc_reg, pc_next;
  logic                  req_reg, req_next;
  logic [PC_BITS-1:0]    addr_reg, addr_next;
  logic                  valid_reg, valid_next;
  logic [INSTR_BITS-1:0] out_reg, out_next;
  logic [PC_BITS-1:0]    ipc_reg, ipc_next;
  logic                  capture;
  logic                  slot_free;

  // A new request may only start once decode has taken (or will take) the held instruction.
  assign slot_free = !valid_reg || !stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_PC;
      req_reg   <= 1'b0;
      addr_reg  <= '0;
      valid_reg <= 1'b0;
      out_reg   <= '0;
      ipc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      req_reg   <= req_next;
      addr_reg  <= addr_next;
      valid_reg <= valid_next;
      out_reg   <= out_next;
      ipc_reg   <= ipc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BOOT:    state_next = IDLE;
      IDLE:    if (!redirect_valid && slot_free) state_next = BUSY;
      BUSY: begin
        if (imem.imem_ack)      state_next = IDLE;
        else if (redirect_valid) state_next = SQUASH;
      end
      SQUASH:  if (imem.imem_ack) state_next = IDLE;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    pc_next   = pc_reg;
    req_next  = req_reg;
    addr_next = addr_reg;
    capture   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (redirect_valid) begin
          pc_next = redirect_pc;
        end else if (slot_free) begin
          req_next  = 1'b1;
          addr_next = pc_reg;
        end
      end
      BUSY: begin
        if (redirect_valid) pc_next = redirect_pc;
        if (imem.imem_ack) begin
          req_next = 1'b0;
          if (!redirect_valid) begin
            capture = 1'b1;
            pc_next = addr_reg + PC_BITS'(PC_INC);
          end
        end
      end
      SQUASH: begin
        // Latest redirect wins; the returning data belongs to the old path.
        if (redirect_valid) pc_next = redirect_pc;
        if (imem.imem_ack)  req_next = 1'b0;
      end
      default: ;
    endcase

    if (redirect_valid)  valid_next = 1'b0;
    else if (capture)    valid_next = 1'b1;
    else if (!stall)     valid_next = 1'b0;
    else                 valid_next = valid_reg;

    out_next = capture ? imem.imem_rdata : out_reg;
    ipc_next = capture ? addr_reg : ipc_reg;
  end

  assign imem.imem_req  = req_reg;
  assign imem.imem_addr = addr_reg;
  assign instr_valid    = valid_reg;
  assign instr_out      = out_reg;
  assign instr_pc       = ipc_reg;

`ifdef FETCH_PERF_EN
  fetch_perf_ctr u_perf (
    .clk            (clk),
    .rst_n          (rst_n),
    .capture        (capture),
    .redirect       (redirect_valid),
    .fetch_count    (fetch_count),
    .redirect_count (redirect_count)
  );
`endif

endmodule

// File: tb/tb_fetch_pc_seq.sv
// Directed bench for fetch_pc_seq; covers counters when FETCH_PERF_EN is defined.
module tb_fetch_pc_seq;
  import fetch_pkg::*;

  localparam int PB = 16;
  localparam int IB = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [PB-1:0] redirect_pc = '0;
  logic          instr_valid;
  logic [IB-1:0] instr_out;
  logic [PB-1:0] instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0]   fetch_count;
  logic [31:0]   redirect_count;
`endif

  int checks = 0;
  int errors = 0;

  fetch_pc_seq_if #(.PC_BITS(PB), .INSTR_BITS(IB)) bus ();

  fetch_pc_seq #(
    .PC_BITS    (PB),
    .INSTR_BITS (IB),
    .RESET_PC   (16'h0000),
    .PC_INC     (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus),
    .instr_valid    (instr_valid),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count    (fetch_count),
    .redirect_count (redirect_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: wait for a request, ack after 'delay' cycles with 'data'.
  task automatic serve(input int delay, input logic [IB-1:0] data,
                       output logic [PB-1:0] addr, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    addr = '0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (bus.imem_req === 1'b1) begin
      addr = bus.imem_addr;
      repeat (delay) step();
      bus.imem_ack = 1'b1;
      bus.imem_rdata = data;
      step();
      bus.imem_ack = 1'b0;
      bus.imem_rdata = '0;
      ok = 1'b1;
      $display("txn addr=%h data=%h", addr, data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0h want 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr got %h want 0000", bus.imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h want 0", instr_valid); end
    checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL rst_out got %h want 0", instr_out); end
    checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL rst_pc got %h want 0000", instr_pc); end
    rst_n = 1'b1;
    step();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL boot_req got %0h want 0", bus.imem_req); end
    step();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %0h want 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL first_addr got %h want 0000", bus.imem_addr); end
  endtask

  task automatic test_sequential();
    logic [PB-1:0] a;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      serve(1, 32'hA000_0000 + 32'(i), a, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL seq_timeout got %0d want 1", ok); end
      checks++; if (a !== 16'(4 * i)) begin errors++; $display("FAIL seq_addr got %h want %h", a, 16'(4 * i)); end
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid got %0h want 1", instr_valid); end
      checks++; if (instr_pc !== 16'(4 * i)) begin errors++; $display("FAIL seq_pc got %h want %h", instr_pc, 16'(4 * i)); end
      checks++; if (instr_out !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL seq_out got %h want %h", instr_out, 32'hA000_0000 + 32'(i)); end
    end
  endtask

  task automatic test_stall();
    logic [PB-1:0] a;
    bit ok;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req got %0h want 0", bus.imem_req); end
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %0h want 1", instr_valid); end
      checks++; if (instr_pc !== 16'h0004) begin errors++; $display("FAIL stall_pc got %h want 0004", instr_pc); end
      checks++; if (instr_out !== 32'hA000_0001) begin errors++; $display("FAIL stall_out got %h want a0000001", instr_out); end
    end
    stall = 1'b0;
    serve(1, 32'hB000_0008, a, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_timeout got %0d want 1", ok); end
    checks++; if (a !== 16'h0008) begin errors++; $display("FAIL stall_next_addr got %h want 0008", a); end
    checks++; if (instr_out !== 32'hB000_0008) begin errors++; $display("FAIL stall_next_out got %h want b0000008", instr_out); end
  endtask

  task automatic test_redirect_busy();
    logic [PB-1:0] a;
    bit ok;
    step();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rb_req got %0h want 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 16'h000C) begin errors++; $display("FAIL rb_addr got %h want 000c", bus.imem_addr); end
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL sq_req got %0h want 1", bus.imem_req); end
      checks++; if (bus.imem_addr !== 16'h000C) begin errors++; $display("FAIL sq_addr got %h want 000c", bus.imem_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL sq_valid got %0h want 0", instr_valid); end
      if (i < 2) step();
    end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL sq_done_req got %0h want 0", bus.imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL sq_discard got %0h want 0", instr_valid); end
    serve(0, 32'hC000_0100, a, ok);
    checks++; if (a !== 16'h0100) begin errors++; $display("FAIL rb_target got %h want 0100", a); end
    checks++; if (instr_pc !== 16'h0100) begin errors++; $display("FAIL rb_pc got %h want 0100", instr_pc); end
    checks++; if (instr_out !== 32'hC000_0100) begin errors++; $display("FAIL rb_out got %h want c0000100", instr_out); end
  endtask

  task automatic test_ack_redirect();
    logic [PB-1:0] a;
    bit ok;
    step();
    checks++; if (bus.imem_addr !== 16'h0104) begin errors++; $display("FAIL ar_addr got %h want 0104", bus.imem_addr); end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0200;
    step();
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    redirect_valid = 1'b0;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL ar_req got %0h want 0", bus.imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %0h want 0", instr_valid); end
    serve(0, 32'hD000_0200, a, ok);
    checks++; if (a !== 16'h0200) begin errors++; $display("FAIL ar_target got %h want 0200", a); end
    checks++; if (instr_out !== 32'hD000_0200) begin errors++; $display("FAIL ar_out got %h want d0000200", instr_out); end
  endtask

  task automatic test_wrap();
    logic [PB-1:0] a;
    bit ok;
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFC;
    step();
    redirect_valid = 1'b0;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL idle_rd_req got %0h want 0", bus.imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL idle_rd_flush got %0h want 0", instr_valid); end
    step();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL idle_rd_lat got %0h want 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 16'hFFFC) begin errors++; $display("FAIL idle_rd_addr got %h want fffc", bus.imem_addr); end
    serve(0, 32'hE000_FFFC, a, ok);
    checks++; if (instr_pc !== 16'hFFFC) begin errors++; $display("FAIL wrap_pc got %h want fffc", instr_pc); end
    serve(0, 32'hF000_0000, a, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wrap_timeout got %0d want 1", ok); end
    checks++; if (a !== 16'h0000) begin errors++; $display("FAIL wrap_addr got %h want 0000", a); end
    checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL wrap_ipc got %h want 0000", instr_pc); end
`ifdef FETCH_PERF_EN
    checks++; if (fetch_count !== 32'd7) begin errors++; $display("FAIL perf_fetch got %0d want 7", fetch_count); end
    checks++; if (redirect_count !== 32'd3) begin errors++; $display("FAIL perf_redir got %0d want 3", redirect_count); end
`endif
  endtask

  task automatic test_reset_busy();
    logic [PB-1:0] a;
    bit ok;
    step();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rbz_req got %0h want 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 16'h0004) begin errors++; $display("FAIL rbz_addr got %h want 0004", bus.imem_addr); end
    rst_n = 1'b0;
    step();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rbz_rst_req got %0h want 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL rbz_rst_addr got %h want 0000", bus.imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rbz_rst_valid got %0h want 0", instr_valid); end
    checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL rbz_rst_out got %h want 0", instr_out); end
    checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL rbz_rst_pc got %h want 0000", instr_pc); end
`ifdef FETCH_PERF_EN
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL rbz_perf_fetch got %0d want 0", fetch_count); end
    checks++; if (redirect_count !== 32'd0) begin errors++; $display("FAIL rbz_perf_redir got %0d want 0", redirect_count); end
`endif
    rst_n = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h5555_AAAA;
    step();
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rbz_stale_ack got %0h want 0", instr_valid); end
    step();
    checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL rbz_boot_addr got %h want 0000", bus.imem_addr); end
    serve(0, 32'h1234_5678, a, ok);
    checks++; if (instr_out !== 32'h1234_5678) begin errors++; $display("FAIL rbz_out got %h want 12345678", instr_out); end
  endtask

  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_busy();
    test_ack_redirect();
    test_wrap();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
